// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//
// Captures the decoded control bits, datapath operands and register specifiers of
// the instruction leaving ID and presents them to EX one cycle later. A branch-taken
// flush from MEM squashes the entering instruction to an all-zero bubble. When the
// ID instruction reads the destination of a load already sitting in EX, a single
// bubble is inserted and the PC and IF/ID register are frozen for that cycle.
//
// Configuration:
//   ID_EX_HAZARD_EN  defined   -> load-use detection and bubble insertion active
//                    undefined -> stall tied 0, pc_write/ifid_write tied 1
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   flush                  squash the instruction entering EX
//   *_in                   decoder control bits, datapath values, specifiers from ID
//   *_out                  registered copies presented to EX
//   valid_out              1 = EX holds a real instruction, 0 = bubble
//   stall                  combinational load-use hazard indication
//   pc_write, ifid_write   combinational enables, both ~stall

module id_ex_stage #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              RegDst_in,
    input  logic              Branch_in,
    input  logic              MemRead_in,
    input  logic              MemtoReg_in,
    input  logic              MemWrite_in,
    input  logic              ALUSrc_in,
    input  logic              RegWrite_in,
    input  logic [1:0]        ALUOp_in,

    input  logic [DATA_W-1:0] pc_plus4_in,
    input  logic [DATA_W-1:0] read_data1_in,
    input  logic [DATA_W-1:0] read_data2_in,
    input  logic [DATA_W-1:0] sign_ext_in,
    input  logic [4:0]        rs_in,
    input  logic [4:0]        rt_in,
    input  logic [4:0]        rd_in,

    output logic              RegDst_out,
    output logic              Branch_out,
    output logic              MemRead_out,
    output logic              MemtoReg_out,
    output logic              MemWrite_out,
    output logic              ALUSrc_out,
    output logic              RegWrite_out,
    output logic [1:0]        ALUOp_out,

    output logic [DATA_W-1:0] pc_plus4_out,
    output logic [DATA_W-1:0] read_data1_out,
    output logic [DATA_W-1:0] read_data2_out,
    output logic [DATA_W-1:0] sign_ext_out,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,

    output logic              valid_out,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write
);

    // Control bundle: {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp}
    localparam int unsigned CTRL_W = 9;

    logic [CTRL_W-1:0] ctrl_in;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [DATA_W-1:0] pc_plus4_d, pc_plus4_q;
    logic [DATA_W-1:0] read_data1_d, read_data1_q;
    logic [DATA_W-1:0] read_data2_d, read_data2_q;
    logic [DATA_W-1:0] sign_ext_d, sign_ext_q;
    logic [4:0]        rs_d, rs_q;
    logic [4:0]        rt_d, rt_q;
    logic [4:0]        rd_d, rd_q;

    logic              hazard;

    assign ctrl_in = {RegDst_in, Branch_in, MemRead_in, MemtoReg_in, MemWrite_in,
                      ALUSrc_in, RegWrite_in, ALUOp_in};

    // Load-use detection looks only at registered EX state and the ID specifiers,
    // so no control input reaches an output combinationally.
`ifdef ID_EX_HAZARD_EN
    logic mem_read_q;
    assign mem_read_q = ctrl_q[6];

    always_comb begin
        hazard = 1'b0;
        // $zero is never a real producer, so rt_out == 0 can't create a hazard.
        if (mem_read_q && (rt_q != 5'd0) && ((rt_q == rs_in) || (rt_q == rt_in))) begin
            hazard = 1'b1;
        end
    end
`else
    assign hazard = 1'b0;
`endif

    assign stall      = hazard;
    assign pc_write   = ~hazard;
    assign ifid_write = ~hazard;

    // Next-state: flush clears everything, a stall clears only control and valid
    // (datapath still tracks ID), otherwise load straight through.
    always_comb begin
        ctrl_d       = ctrl_in;
        valid_d      = 1'b1;
        pc_plus4_d   = pc_plus4_in;
        read_data1_d = read_data1_in;
        read_data2_d = read_data2_in;
        sign_ext_d   = sign_ext_in;
        rs_d         = rs_in;
        rt_d         = rt_in;
        rd_d         = rd_in;

        if (flush) begin
            ctrl_d       = '0;
            valid_d      = 1'b0;
            pc_plus4_d   = '0;
            read_data1_d = '0;
            read_data2_d = '0;
            sign_ext_d   = '0;
            rs_d         = '0;
            rt_d         = '0;
            rd_d         = '0;
        end else if (hazard) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q       <= '0;
            valid_q      <= 1'b0;
            pc_plus4_q   <= '0;
            read_data1_q <= '0;
            read_data2_q <= '0;
            sign_ext_q   <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            valid_q      <= valid_d;
            pc_plus4_q   <= pc_plus4_d;
            read_data1_q <= read_data1_d;
            read_data2_q <= read_data2_d;
            sign_ext_q   <= sign_ext_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
        end
    end

    assign {RegDst_out, Branch_out, MemRead_out, MemtoReg_out, MemWrite_out,
            ALUSrc_out, RegWrite_out, ALUOp_out} = ctrl_q;

    assign valid_out      = valid_q;
    assign pc_plus4_out   = pc_plus4_q;
    assign read_data1_out = read_data1_q;
    assign read_data2_out = read_data2_q;
    assign sign_ext_out   = sign_ext_q;
    assign rs_out         = rs_q;
    assign rt_out         = rt_q;
    assign rd_out         = rd_q;

endmodule
